// File: rtl/vram_responder.sv
// vram_responder: emulates the two 8-bit VRAM chips (A/B) behind a PPU.
// All PPU-driven pins pass through a SYNC_STAGES-deep synchronizer. Strobe
// edges are detected on the synchronized copies. Reads are served from
// internal block RAM, and writes are captured on the rising edge of the
// write strobe. A host port preloads both chips while the bus is idle.
// Optional feature macro: VRAM_RESP_TRACE_EN adds a one-entry event trace port.
module vram_responder #(
    parameter int ADDR_BITS   = 10,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 vrd_n,
    input  logic                 vawr_n,
    input  logic                 vbwr_n,
    input  logic                 va14,
    input  logic [13:0]          vaa,
    input  logic [13:0]          vab,
    input  logic [7:0]           vda_i,
    input  logic [7:0]           vdb_i,
    output logic [7:0]           vda_o,
    output logic [7:0]           vdb_o,
    output logic                 vd_tristate,
    output logic                 lvl_vd_dir,
    output logic                 lvl_va_dir,
    input  logic                 host_we,
    input  logic [ADDR_BITS-1:0] host_addr,
    input  logic [7:0]           host_da,
    input  logic [7:0]           host_db,
    output logic                 host_busy,
    output logic [15:0]          rd_count,
    output logic [15:0]          wr_count,
    output logic [7:0]           err_count
`ifdef VRAM_RESP_TRACE_EN
    ,
    output logic                 trace_valid,
    input  logic                 trace_ready,
    output logic [31:0]          trace_data,
    output logic                 trace_overflow
`endif
);
    // Synchronized bundle is {vrd_n, vawr_n, vbwr_n, va14, vaa, vab, vda_i, vdb_i}.
    localparam int SW = 48;
    localparam logic [SW-1:0] SYNC_INIT = {3'b111, 45'd0};

    typedef enum logic [2:0] {IDLE, FETCH, DRIVE, WRITE, FAULT} state_t;

    logic [SW-1:0] ppu_bus;
    logic [SW-1:0] synced;
    assign ppu_bus = {vrd_n, vawr_n, vbwr_n, va14, vaa, vab, vda_i, vdb_i};

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            logic [SW-1:0] stage_reg;
            if (gi == 0) begin : g_first
                // First synchronizer stage samples the raw pins; strobes reset inactive
                always_ff @(posedge clock) begin
                    if (!reset) stage_reg <= SYNC_INIT;
                    else        stage_reg <= ppu_bus;
                end
            end else begin : g_rest
                // Later stages shift the bundle along the chain
                always_ff @(posedge clock) begin
                    if (!reset) stage_reg <= SYNC_INIT;
                    else        stage_reg <= g_sync[gi-1].stage_reg;
                end
            end
        end
    endgenerate
    assign synced = g_sync[SYNC_STAGES-1].stage_reg;

    logic        rd_s, wa_s, wb_s;
    logic [14:0] full_a, full_b;
    logic [7:0]  vda_s, vdb_s;
    assign rd_s   = synced[47];
    assign wa_s   = synced[46];
    assign wb_s   = synced[45];
    assign full_a = {synced[44], synced[43:30]};
    assign full_b = {synced[44], synced[29:16]};
    assign vda_s  = synced[15:8];
    assign vdb_s  = synced[7:0];

    state_t      state_reg, state_next;
    logic        rd_prev_reg, wa_prev_reg, wb_prev_reg;
    logic [14:0] lat_a_reg, lat_b_reg;
    logic [7:0]  vda_o_reg, vdb_o_reg;
    logic [15:0] rd_count_reg, wr_count_reg;
    logic [7:0]  err_count_reg;
    logic        err_inc, rd_done, idle_free;
    logic        commit_a, commit_b, host_wr;

    logic rd_fall, wa_fall, wb_fall, wa_rise, wb_rise;
    assign rd_fall = rd_prev_reg & ~rd_s;
    assign wa_fall = wa_prev_reg & ~wa_s;
    assign wb_fall = wb_prev_reg & ~wb_s;
    assign wa_rise = ~wa_prev_reg & wa_s;
    assign wb_rise = ~wb_prev_reg & wb_s;

    // Commits only in WRITE, and not on a cycle that is turning into a fault
    assign commit_a = reset && (state_reg == WRITE) && wa_rise && !rd_fall;
    assign commit_b = reset && (state_reg == WRITE) && wb_rise && !rd_fall;
    assign host_wr  = reset && host_we && idle_free;

    logic [7:0] mem_a [2**ADDR_BITS];
    logic [7:0] mem_b [2**ADDR_BITS];

    // Chip RAM write ports: host preload in IDLE, PPU commits in WRITE
    always_ff @(posedge clock) begin
        if (host_wr) begin
            mem_a[host_addr] <= host_da;
            mem_b[host_addr] <= host_db;
        end else begin
            if (commit_a) mem_a[full_a[ADDR_BITS-1:0]] <= vda_s;
            if (commit_b) mem_b[full_b[ADDR_BITS-1:0]] <= vdb_s;
        end
    end

    // State register plus edge history, address latch, read data and counters
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_reg     <= IDLE;
            rd_prev_reg   <= 1'b1;
            wa_prev_reg   <= 1'b1;
            wb_prev_reg   <= 1'b1;
            lat_a_reg     <= '0;
            lat_b_reg     <= '0;
            vda_o_reg     <= '0;
            vdb_o_reg     <= '0;
            rd_count_reg  <= '0;
            wr_count_reg  <= '0;
            err_count_reg <= '0;
        end else begin
            state_reg   <= state_next;
            rd_prev_reg <= rd_s;
            wa_prev_reg <= wa_s;
            wb_prev_reg <= wb_s;
            if (state_reg == IDLE && state_next == FETCH) begin
                lat_a_reg <= full_a;
                lat_b_reg <= full_b;
            end
            if (state_reg == FETCH) begin
                vda_o_reg <= mem_a[lat_a_reg[ADDR_BITS-1:0]];
                vdb_o_reg <= mem_b[lat_b_reg[ADDR_BITS-1:0]];
            end
            rd_count_reg <= rd_count_reg + {15'd0, rd_done};
            wr_count_reg <= wr_count_reg + {15'd0, commit_a} + {15'd0, commit_b};
            if (err_inc && err_count_reg != 8'hFF) err_count_reg <= err_count_reg + 8'd1;
        end
    end

    // Next-state logic and the per-transition event strobes
    always_comb begin
        state_next = state_reg;
        err_inc    = 1'b0;
        rd_done    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!rd_s && (!wa_s || !wb_s)) begin
                    err_inc    = 1'b1;
                    state_next = FAULT;
                end else if (rd_fall) begin
                    state_next = FETCH;
                end else if (rd_s && (wa_fall || wb_fall)) begin
                    state_next = WRITE;
                end
            end
            FETCH: begin
                if (wa_fall || wb_fall) begin
                    err_inc    = 1'b1;
                    state_next = FAULT;
                end else begin
                    state_next = DRIVE;
                end
            end
            DRIVE: begin
                if (wa_fall || wb_fall) begin
                    err_inc    = 1'b1;
                    state_next = FAULT;
                end else if (rd_s) begin
                    rd_done    = 1'b1;
                    state_next = IDLE;
                end
            end
            WRITE: begin
                if (rd_fall) begin
                    err_inc    = 1'b1;
                    state_next = FAULT;
                end else if (wa_s && wb_s) begin
                    state_next = IDLE;
                end
            end
            FAULT: begin
                if (rd_s && wa_s && wb_s) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Output decode: the data bus is driven only while in DRIVE
    always_comb begin
        vd_tristate = (state_reg != DRIVE);
        lvl_vd_dir  = (state_reg == DRIVE);
        lvl_va_dir  = 1'b0;
        idle_free   = (state_reg == IDLE) && rd_s && wa_s && wb_s;
        host_busy   = !idle_free;
    end

    assign vda_o     = vda_o_reg;
    assign vdb_o     = vdb_o_reg;
    assign rd_count  = rd_count_reg;
    assign wr_count  = wr_count_reg;
    assign err_count = err_count_reg;

`ifdef VRAM_RESP_TRACE_EN
    logic        trace_valid_reg, trace_overflow_reg;
    logic [31:0] trace_data_reg;
    logic        ev_valid, ev_extra;
    logic [31:0] ev_data;

    // Select the event for this cycle; a simultaneous B commit is the one dropped
    always_comb begin
        ev_valid = 1'b0;
        ev_extra = 1'b0;
        ev_data  = '0;
        if (rd_done) begin
            ev_valid = 1'b1;
            ev_data  = {2'd1, 6'd0, 1'b0, lat_a_reg, vda_o_reg};
        end else if (commit_a) begin
            ev_valid = 1'b1;
            ev_extra = commit_b;
            ev_data  = {2'd2, 6'd0, 1'b0, full_a, vda_s};
        end else if (commit_b) begin
            ev_valid = 1'b1;
            ev_data  = {2'd3, 6'd0, 1'b0, full_b, vdb_s};
        end
    end

    // One-entry trace buffer with sticky overflow
    always_ff @(posedge clock) begin
        if (!reset) begin
            trace_valid_reg    <= 1'b0;
            trace_data_reg     <= '0;
            trace_overflow_reg <= 1'b0;
        end else begin
            if (trace_valid_reg && trace_ready) trace_valid_reg <= 1'b0;
            if (ev_valid) begin
                if (!trace_valid_reg || trace_ready) begin
                    trace_valid_reg <= 1'b1;
                    trace_data_reg  <= ev_data;
                end else begin
                    trace_overflow_reg <= 1'b1;
                end
            end
            if (ev_extra) trace_overflow_reg <= 1'b1;
        end
    end

    assign trace_valid    = trace_valid_reg;
    assign trace_data     = trace_data_reg;
    assign trace_overflow = trace_overflow_reg;
`else
    // Upper latched address bits only feed the trace records
    logic unused_lat;
    assign unused_lat = &{1'b0, lat_a_reg, lat_b_reg};
`endif

endmodule

// File: tb/tb_vram_responder.sv
// Directed testbench for vram_responder (default build, trace port absent).
module tb_vram_responder;
    logic        clock = 1'b0;
    logic        reset;
    logic        vrd_n, vawr_n, vbwr_n, va14;
    logic [13:0] vaa, vab;
    logic [7:0]  vda_i, vdb_i, vda_o, vdb_o;
    logic        vd_tristate, lvl_vd_dir, lvl_va_dir;
    logic        host_we;
    logic [9:0]  host_addr;
    logic [7:0]  host_da, host_db;
    logic        host_busy;
    logic [15:0] rd_count, wr_count;
    logic [7:0]  err_count;

    int n_cmp = 0;
    int n_bad = 0;

    vram_responder #(.ADDR_BITS(10), .SYNC_STAGES(2)) dut (
        .clock(clock), .reset(reset),
        .vrd_n(vrd_n), .vawr_n(vawr_n), .vbwr_n(vbwr_n), .va14(va14),
        .vaa(vaa), .vab(vab), .vda_i(vda_i), .vdb_i(vdb_i),
        .vda_o(vda_o), .vdb_o(vdb_o),
        .vd_tristate(vd_tristate), .lvl_vd_dir(lvl_vd_dir), .lvl_va_dir(lvl_va_dir),
        .host_we(host_we), .host_addr(host_addr), .host_da(host_da), .host_db(host_db),
        .host_busy(host_busy),
        .rd_count(rd_count), .wr_count(wr_count), .err_count(err_count)
    );

    always #5 clock = ~clock;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) @(negedge clock);
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_addr(input logic [14:0] a);
        va14 = a[14];
        vaa  = a[13:0];
        vab  = a[13:0];
    endtask

    task automatic preload(input logic [9:0] a, input logic [7:0] da, input logic [7:0] db);
        host_addr = a; host_da = da; host_db = db; host_we = 1'b1;
        tick(1);
        host_we = 1'b0;
        $display("preload addr=0x%03h A=0x%02h B=0x%02h", a, da, db);
    endtask

    // Full read cycle: drive window then release, checking both phases
    task automatic read_at(input string tag, input logic [14:0] a,
                           input logic [7:0] ea, input logic [7:0] eb);
        set_addr(a);
        vrd_n = 1'b0;
        tick(4);
        check({tag, "_drive"}, {31'd0, vd_tristate}, 32'd0);
        check({tag, "_a"}, {24'd0, vda_o}, {24'd0, ea});
        check({tag, "_b"}, {24'd0, vdb_o}, {24'd0, eb});
        tick(4);
        vrd_n = 1'b1;
        tick(4);
        check({tag, "_release"}, {31'd0, vd_tristate}, 32'd1);
        $display("read addr=0x%04h A=0x%02h B=0x%02h rd_count=%0d", a, vda_o, vdb_o, rd_count);
    endtask

    task automatic write_pulse(input logic [14:0] a, input logic [7:0] da, input logic [7:0] db,
                               input logic do_a, input logic do_b);
        set_addr(a);
        vda_i = da; vdb_i = db;
        vawr_n = !do_a; vbwr_n = !do_b;
        tick(4);
        vawr_n = 1'b1; vbwr_n = 1'b1;
        tick(4);
        $display("write addr=0x%04h A=0x%02h(%0b) B=0x%02h(%0b) wr_count=%0d", a, da, do_a, db, do_b, wr_count);
    endtask

    initial begin
        reset = 1'b0;
        vrd_n = 1'b1; vawr_n = 1'b1; vbwr_n = 1'b1;
        va14 = 1'b0; vaa = '0; vab = '0; vda_i = '0; vdb_i = '0;
        host_we = 1'b0; host_addr = '0; host_da = '0; host_db = '0;
        tick(3);
        check("rst_tristate", {31'd0, vd_tristate}, 32'd1);
        check("rst_vd_dir", {31'd0, lvl_vd_dir}, 32'd0);
        check("rst_va_dir", {31'd0, lvl_va_dir}, 32'd0);
        check("rst_vda_o", {24'd0, vda_o}, 32'd0);
        check("rst_rd_count", {16'd0, rd_count}, 32'd0);
        check("rst_wr_count", {16'd0, wr_count}, 32'd0);
        check("rst_err_count", {24'd0, err_count}, 32'd0);
        reset = 1'b1;
        tick(2);
        check("idle_host_busy", {31'd0, host_busy}, 32'd0);

        preload(10'h005, 8'hA1, 8'hB2);
        preload(10'h3FF, 8'hEE, 8'h66);

        // Drive latency: synchronizer (2) + 2 cycles after the strobe falls
        set_addr(15'h0005);
        vrd_n = 1'b0;
        tick(3);
        check("rd_not_yet", {31'd0, vd_tristate}, 32'd1);
        tick(1);
        check("rd_tristate", {31'd0, vd_tristate}, 32'd0);
        check("rd_vd_dir", {31'd0, lvl_vd_dir}, 32'd1);
        check("rd_vda", {24'd0, vda_o}, 32'hA1);
        check("rd_vdb", {24'd0, vdb_o}, 32'hB2);
        check("rd_host_busy", {31'd0, host_busy}, 32'd1);
        tick(6);
        vrd_n = 1'b1;
        tick(4);
        check("rd_rel_tristate", {31'd0, vd_tristate}, 32'd1);
        check("rd_rel_vd_dir", {31'd0, lvl_vd_dir}, 32'd0);
        check("rd_count1", {16'd0, rd_count}, 32'd1);
        $display("read addr=0x0005 A=0x%02h B=0x%02h rd_count=%0d", vda_o, vdb_o, rd_count);

        // Upper address bits alias onto the same 10-bit index
        read_at("alias", 15'h4405, 8'hA1, 8'hB2);

        write_pulse(15'h03FF, 8'h5C, 8'h77, 1'b1, 1'b0);
        check("wrA_count", {16'd0, wr_count}, 32'd1);
        read_at("wrA_rb", 15'h03FF, 8'h5C, 8'h66);

        write_pulse(15'h0010, 8'h11, 8'h22, 1'b1, 1'b1);
        check("wrAB_count", {16'd0, wr_count}, 32'd3);
        read_at("wrAB_rb", 15'h0010, 8'h11, 8'h22);
        check("rd_count4", {16'd0, rd_count}, 32'd4);

        // Host write while busy is dropped
        set_addr(15'h0005);
        vrd_n = 1'b0;
        tick(4);
        check("busy_in_drive", {31'd0, host_busy}, 32'd1);
        preload(10'h005, 8'hFF, 8'hFF);
        tick(2);
        vrd_n = 1'b1;
        tick(4);
        read_at("busy_ignored", 15'h0005, 8'hA1, 8'hB2);
        check("rd_count6", {16'd0, rd_count}, 32'd6);

        // Write strobe during DRIVE faults and holds the bus off
        set_addr(15'h0005);
        vrd_n = 1'b0;
        tick(4);
        check("flt_drive", {31'd0, vd_tristate}, 32'd0);
        vbwr_n = 1'b0;
        tick(3);
        check("flt_release", {31'd0, vd_tristate}, 32'd1);
        check("flt_err", {24'd0, err_count}, 32'd1);
        vbwr_n = 1'b1;
        tick(4);
        check("flt_hold", {31'd0, vd_tristate}, 32'd1);
        check("flt_busy", {31'd0, host_busy}, 32'd1);
        vrd_n = 1'b1;
        tick(4);
        check("flt_exit_busy", {31'd0, host_busy}, 32'd0);
        check("flt_rd_count", {16'd0, rd_count}, 32'd6);
        check("flt_wr_count", {16'd0, wr_count}, 32'd3);
        $display("fault drive err_count=%0d", err_count);

        // Read and write strobes falling together in IDLE
        vrd_n = 1'b0; vawr_n = 1'b0;
        tick(4);
        check("coll_err", {24'd0, err_count}, 32'd2);
        check("coll_tristate", {31'd0, vd_tristate}, 32'd1);
        vrd_n = 1'b1; vawr_n = 1'b1;
        tick(4);
        check("coll_wr_count", {16'd0, wr_count}, 32'd3);
        check("coll_idle", {31'd0, host_busy}, 32'd0);
        $display("fault collide err_count=%0d", err_count);

        // Reset while driving releases the bus; memory survives
        set_addr(15'h0005);
        vrd_n = 1'b0;
        tick(5);
        check("mid_drive", {31'd0, vd_tristate}, 32'd0);
        reset = 1'b0;
        tick(1);
        check("mid_rst_tristate", {31'd0, vd_tristate}, 32'd1);
        check("mid_rst_vd_dir", {31'd0, lvl_vd_dir}, 32'd0);
        check("mid_rst_rd", {16'd0, rd_count}, 32'd0);
        check("mid_rst_wr", {16'd0, wr_count}, 32'd0);
        check("mid_rst_err", {24'd0, err_count}, 32'd0);
        check("mid_rst_vda", {24'd0, vda_o}, 32'd0);
        vrd_n = 1'b1;
        tick(1);
        reset = 1'b1;
        tick(4);
        read_at("post_rst", 15'h0005, 8'hA1, 8'hB2);
        read_at("post_rst_wr", 15'h0010, 8'h11, 8'h22);
        check("post_rst_rd", {16'd0, rd_count}, 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
